// File: rtl/program_loader_pkg.sv
// Shared definitions for the byte-serial program loader.
// State encoding, default geometry and instruction word split.
package program_loader_pkg;

    localparam int INS_WIDTH_DEF  = 13;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int PROG_LEN_DEF   = 64;
    localparam int HI_USED_BITS   = INS_WIDTH_DEF - 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LO,
        HI,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    function automatic logic takes_byte(input state_t s);
        return s inside {LEN, LO, HI, CHK};
    endfunction

    function automatic logic is_busy(input state_t s);
        return s inside {LEN, LO, HI, WRITE, CHK};
    endfunction

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader that fills program memory and holds the
// core in reset until a checksum-verified load completes.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INS_WIDTH  = INS_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int PROG_LEN   = PROG_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [7:0]            inData,
    input  logic                  inValid,
    output logic                  inReady,
    output logic                  pmWE,
    output logic [ADDR_WIDTH-1:0] pmAddr,
    output logic [INS_WIDTH-1:0]  pmData,
    output logic                  coreReset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int HI_W = INS_WIDTH - 8;

    state_t                state;
    state_t                state_n;
    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH-1:0] last;
    logic [7:0]            sum;
    logic [7:0]            lo;
    logic                  we_q;
    logic                  fire;
    logic                  len_bad;
    logic                  hi_bad;

    assign fire    = inValid && inReady;
    assign len_bad = (inData == 8'd0) || (int'(inData) > PROG_LEN);
    assign hi_bad  = |inData[7:HI_W];

    // Reset must suppress the write strobe within the very cycle it is seen.
    assign pmWE = we_q && !Reset;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = LEN;
            LEN: if (fire) state_n = len_bad ? ERR : LO;
            LO: if (fire) state_n = HI;
            HI: if (fire) state_n = hi_bad ? ERR : WRITE;
            WRITE: state_n = (index == last) ? CHK : LO;
            CHK: if (fire) state_n = (inData == sum) ? DONE : ERR;
            DONE: if (start) state_n = LEN;
            ERR: if (start) state_n = LEN;
        endcase
        if (Reset) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= IDLE;
            inReady   <= 1'b0;
            we_q      <= 1'b0;
            pmAddr    <= '0;
            pmData    <= '0;
            coreReset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            index     <= '0;
            last      <= '0;
            sum       <= '0;
            lo        <= '0;
        end else begin
            state     <= state_n;
            inReady   <= takes_byte(state_n);
            we_q      <= (state_n == WRITE);
            busy      <= is_busy(state_n);
            done      <= (state_n == DONE);
            error     <= (state_n == ERR);
            coreReset <= (state_n != DONE);
            unique case (state)
                LEN: begin
                    if (fire && !len_bad) begin
                        last  <= ADDR_WIDTH'(inData - 8'd1);
                        index <= '0;
                        sum   <= '0;
                    end
                end
                LO: begin
                    if (fire) begin
                        lo  <= inData;
                        sum <= sum + inData;
                    end
                end
                HI: begin
                    if (fire && !hi_bad) begin
                        sum    <= sum + inData;
                        pmAddr <= index;
                        pmData <= {inData[HI_W-1:0], lo};
                    end
                end
                WRITE: begin
                    if (index != last) index <= index + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-serial program loader sitting directly upstream of the core's ProgramMemory. It accepts a framed byte stream over a valid/ready handshake and assembles 13-bit instruction words. It writes them into program memory at addresses 0..N-1 and holds the core in reset until a checksum-verified load completes. It is the only writer of program memory; the core's PC/decoder path stays read-only.

## Interface
Parameters:
- INS_WIDTH, 13, instruction word width
- ADDR_WIDTH, 6, program memory address width
- PROG_LEN, 64, maximum words per load

Ports:
- clk  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- start  in  1  request a new load; sampled only in IDLE, DONE, ERR
- inData  in  8  stream byte
- inValid  in  1  inData valid
- inReady  out  1  loader can accept a byte this cycle
- pmWE  out  1  program memory write enable, one-cycle pulse per word
- pmAddr  out  ADDR_WIDTH  program memory write address
- pmData  out  INS_WIDTH  program memory write data
- coreReset  out  1  active-high hold for PC/RF/accumulator/carry (top drives core nReset = nReset & ~coreReset)
- busy  out  1  load in progress
- done  out  1  last load succeeded (sticky)
- error  out  1  last load failed (sticky)

## Operation
- Frame format:
  - LEN byte L, with 1 ≤ L ≤ PROG_LEN.
  - L word pairs, LO byte then HI byte; word = {HI[4:0], LO}.
  - CHK byte = 8-bit sum mod 256 of all 2L word bytes. LEN is excluded.
- A byte transfers on a rising edge with inValid && inReady. inReady is a function of state only: high in LEN, LO, HI, CHK; low elsewhere.
- States and transitions:
  - IDLE: start → LEN.
  - LEN: L=0 or L>PROG_LEN → ERR. Otherwise latch L, clear index and sum → LO.
  - LO: latch byte, add it to sum → HI.
  - HI:
    - HI[7:5]≠0 → ERR, no write.
    - Otherwise add the byte to sum, register pmData/pmAddr=index → WRITE.
  - WRITE: pmWE=1 for exactly this cycle.
    - index==L-1 → CHK.
    - Otherwise index+1 → LO.
  - CHK: byte==sum → DONE, else → ERR.
  - DONE / ERR: start → LEN, clearing done/error.
- busy=1 in LEN..CHK.
- coreReset=1 in every state except DONE.
- done=1 only in DONE; error=1 only in ERR.
- start in LEN..CHK is ignored.
- Words written before an error stay in memory; the core stays held.
- Addresses ≥ L are never written.

## Timing
- Reset values: state IDLE, inReady 0, pmWE 0, pmAddr 0, pmData 0, coreReset 1, busy 0, done 0, error 0, index 0, sum 0.
- Reset asserted mid-load → IDLE on the next edge. No pmWE is issued that cycle, even from WRITE.
- start accepted at edge t: inReady=1 from cycle t+1.
- Minimum 3 cycles per word (LO, HI, WRITE). Minimum load = 2 + 3L cycles with inValid held high.
- pmWE rises the cycle after the HI byte is accepted, with pmAddr/pmData stable during that cycle.
- Stalled inValid: the loader waits in its state indefinitely; there is no timeout.
- After the CHK byte is accepted with a match: coreReset falls and done rises on the same edge, so the core fetches address 0 the following cycle.
- Sum arithmetic is 8-bit wrap-around; carries are discarded.
- index is ADDR_WIDTH bits. L=PROG_LEN ends at index 63 without wrapping.

## Structure
- program_loader_pkg holds:
  - state enum (IDLE, LEN, LO, HI, WRITE, CHK, DONE, ERR);
  - INS_WIDTH, ADDR_WIDTH, PROG_LEN defaults;
  - HI_USED_BITS = INS_WIDTH-8.
- Single module; no sub-module.
- ProgramMemory gains a synchronous write port (pmWE/pmAddr/pmData) and keeps its combinational read.
- top instantiates program_loader and gates core reset with coreReset.

## Test plan
- Load L=2, words 0x1ABC, 0x0005: bytes 02 BC 1A 05 00 DB → pmWE at addr 0 with data 0x1ABC, then at addr 1 with data 0x0005; done=1; coreReset falls on the CHK edge.
- Same frame with CHK=0xDA → both words written, error=1, coreReset stays 1, done=0.
- LEN=0x00 and separately LEN=0x41 → ERR immediately, zero pmWE pulses.
- HI byte 0x20 → ERR, no pmWE for that word.
- Randomly toggled inValid on a L=64 frame → exactly 64 pmWE pulses at addresses 0..63, done=1, no write at address 0 after the last.
- Reset asserted in the WRITE cycle of word 3 → no pmWE that cycle; IDLE, coreReset=1, busy=0. A subsequent start plus a full frame loads correctly.
